// File: rtl/alsu_cmd_feeder_pkg.sv
// Shared ALSU definitions: opcode encoding, the packed command word,
// the idle (NOP) command and the legality check used by the issue stage.
package enums;

    typedef enum logic [2:0] {
        OR        = 3'd0,
        XOR       = 3'd1,
        ADD       = 3'd2,
        MULT      = 3'd3,
        SHIFT     = 3'd4,
        ROTATE    = 3'd5,
        INVALID_6 = 3'd6,
        INVALID_7 = 3'd7
    } opcode_e;

    // Field order matches the ALSU pin order driven by the feeder.
    typedef struct packed {
        logic [2:0] opcode;
        logic [2:0] A;
        logic [2:0] B;
        logic       cin;
        logic       serial_in;
        logic       red_op_A;
        logic       red_op_B;
        logic       bypass_A;
        logic       bypass_B;
        logic       direction;
    } alsu_cmd_t;

    // All-zero command: an OR of 0 and 0, harmless to the ALSU.
    localparam alsu_cmd_t ALSU_NOP = '0;

    // A command is illegal for an unused opcode, or when a reduction is
    // requested on an operation that has no reduction form.
    function automatic logic is_invalid(alsu_cmd_t c);
        logic badOpcode;
        logic badReduce;
        badOpcode = (c.opcode == INVALID_6) || (c.opcode == INVALID_7);
        badReduce = (c.red_op_A || c.red_op_B) &&
                    (c.opcode != OR) && (c.opcode != XOR);
        return badOpcode || badReduce;
    endfunction

endpackage

// File: rtl/alsu_cmd_feeder_fifo.sv
// Small synchronous FIFO holding {command, tag} entries for the feeder.
// Pointers carry one extra wrap bit so full and empty are distinguishable.
module alsu_cmd_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 20
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wrPtr_q, wrPtr_d;
    logic [AW:0]      rdPtr_q, rdPtr_d;
    logic             doPush;
    logic             doPop;

    assign full   = (wrPtr_q[AW] != rdPtr_q[AW]) &&
                    (wrPtr_q[AW-1:0] == rdPtr_q[AW-1:0]);
    assign empty  = (wrPtr_q == rdPtr_q);
    assign doPush = push && !full;
    assign doPop  = pop && !empty;
    assign dout   = mem_q[rdPtr_q[AW-1:0]];

    // Next pointer values advance only on accepted pushes and pops.
    always_comb begin
        wrPtr_d = wrPtr_q;
        rdPtr_d = rdPtr_q;
        if (doPush) wrPtr_d = wrPtr_q + (AW+1)'(1);
        if (doPop)  rdPtr_d = rdPtr_q + (AW+1)'(1);
    end

    // Pointer registers; reset empties the FIFO without touching storage.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wrPtr_q <= '0;
            rdPtr_q <= '0;
        end else begin
            wrPtr_q <= wrPtr_d;
            rdPtr_q <= rdPtr_d;
        end
    end

    // Entry storage, written at the tail on every accepted push.
    always_ff @(posedge clk) begin
        if (doPush) mem_q[wrPtr_q[AW-1:0]] <= din;
    end

endmodule

// File: rtl/alsu_cmd_feeder.sv
// Issue stage in front of the ALSU: buffers tagged commands, drives one
// command (or a NOP) onto the registered ALSU pins per cycle, and follows
// each issued command through the ALSU latency to return its result.
module alsu_cmd_feeder
    import enums::*;
#(
    parameter int DEPTH   = 4,
    parameter int LATENCY = 2,
    parameter int TAG_W   = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  alsu_cmd_t        cmd,
    input  logic [TAG_W-1:0] cmd_tag,
    input  logic             hold,
    output logic [2:0]       opcode,
    output logic [2:0]       A,
    output logic [2:0]       B,
    output logic             cin,
    output logic             serial_in,
    output logic             red_op_A,
    output logic             red_op_B,
    output logic             bypass_A,
    output logic             bypass_B,
    output logic             direction,
    input  logic [5:0]       alsu_out,
    output logic             res_valid,
    output logic [5:0]       res_out,
    output logic [TAG_W-1:0] res_tag,
    output logic             res_invalid,
    output logic [7:0]       err_cnt
);

    localparam int ENTRY_W = $bits(alsu_cmd_t) + TAG_W;

    typedef struct packed {
        logic             valid;
        logic [TAG_W-1:0] tag;
        logic             invalid;
    } track_t;

    logic               readyEn_q;
    logic               fifoFull;
    logic               fifoEmpty;
    logic [ENTRY_W-1:0] fifoDout;
    alsu_cmd_t          headCmd;
    logic [TAG_W-1:0]   headTag;
    logic               headInvalid;
    logic               doPush;
    logic               doIssue;

    alsu_cmd_t          pins_q, pins_d;
    track_t             track_q [LATENCY+1];
    track_t             stage0_d;
    track_t             res_q;
    logic [5:0]         resOut_q;
    logic [7:0]         errCnt_q, errCnt_d;

    // cmd_ready is held low until the first edge after reset releases.
    assign cmd_ready = readyEn_q && !fifoFull;
    assign doPush    = cmd_valid && cmd_ready;
    assign doIssue   = !fifoEmpty && !hold;

    alsu_cmd_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (ENTRY_W)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (doPush),
        .pop   (doIssue),
        .din   ({cmd, cmd_tag}),
        .dout  (fifoDout),
        .full  (fifoFull),
        .empty (fifoEmpty)
    );

    assign {headCmd, headTag} = fifoDout;
    assign headInvalid        = is_invalid(headCmd);

    // Select what the pins, the tracking pipe head and the error counter
    // take on this edge; an idle edge drives NOP and tracks nothing.
    always_comb begin
        pins_d   = ALSU_NOP;
        stage0_d = '0;
        errCnt_d = errCnt_q;
        if (doIssue) begin
            pins_d   = headCmd;
            stage0_d = '{valid: 1'b1, tag: headTag, invalid: headInvalid};
            if (headInvalid && (errCnt_q != 8'hFF)) errCnt_d = errCnt_q + 8'd1;
        end
    end

    // Ready enable, ALSU pin register and saturating error counter.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            readyEn_q <= 1'b0;
            pins_q    <= ALSU_NOP;
            errCnt_q  <= '0;
        end else begin
            readyEn_q <= 1'b1;
            pins_q    <= pins_d;
            errCnt_q  <= errCnt_d;
        end
    end

    // Tracking pipe shifts every edge so results line up with alsu_out.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            track_q <= '{default: '0};
        end else begin
            track_q[0] <= stage0_d;
            for (int i = 1; i <= LATENCY; i++) track_q[i] <= track_q[i-1];
        end
    end

    // Result registers pair the last pipe stage with the ALSU output.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            res_q    <= '0;
            resOut_q <= '0;
        end else begin
            res_q    <= track_q[LATENCY];
            resOut_q <= alsu_out;
        end
    end

    assign {opcode, A, B, cin, serial_in, red_op_A, red_op_B,
            bypass_A, bypass_B, direction} = pins_q;

    assign res_valid   = res_q.valid;
    assign res_tag     = res_q.tag;
    assign res_invalid = res_q.invalid;
    assign res_out     = resOut_q;
    assign err_cnt     = errCnt_q;

endmodule

// File: tb/tb_alsu_cmd_feeder.sv
// Bench for alsu_cmd_feeder: a stand-in ALSU with two edges of latency,
// a queue-based reference model compared every cycle, and directed tests.
module tb_alsu_cmd_feeder;
    import enums::*;

    localparam int DEPTH   = 4;
    localparam int LATENCY = 2;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    alsu_cmd_t  cmd = '0;
    logic [3:0] cmd_tag = '0;
    logic       hold = 1'b0;
    logic [2:0] opcode, A, B;
    logic       cin, serial_in, red_op_A, red_op_B, bypass_A, bypass_B, direction;
    logic [5:0] alsu_out;
    logic       res_valid;
    logic [5:0] res_out;
    logic [3:0] res_tag;
    logic       res_invalid;
    logic [7:0] err_cnt;

    int total = 0;
    int bad   = 0;

    alsu_cmd_feeder #(.DEPTH(DEPTH), .LATENCY(LATENCY), .TAG_W(4)) dut (
        .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd(cmd), .cmd_tag(cmd_tag), .hold(hold),
        .opcode(opcode), .A(A), .B(B), .cin(cin), .serial_in(serial_in),
        .red_op_A(red_op_A), .red_op_B(red_op_B), .bypass_A(bypass_A),
        .bypass_B(bypass_B), .direction(direction), .alsu_out(alsu_out),
        .res_valid(res_valid), .res_out(res_out), .res_tag(res_tag),
        .res_invalid(res_invalid), .err_cnt(err_cnt)
    );

    always #5 clk = ~clk;

    // Stand-in ALSU arithmetic; only needs to be deterministic per command.
    function automatic logic [5:0] fakeAlsu(alsu_cmd_t c);
        case (c.opcode)
            3'd0:    return {3'b000, c.A | c.B};
            3'd1:    return {3'b000, c.A ^ c.B};
            3'd2:    return 6'(c.A) + 6'(c.B) + 6'(c.cin);
            3'd3:    return 6'(c.A) * 6'(c.B);
            3'd4:    return {c.A, c.B};
            3'd5:    return {c.B, c.A};
            default: return 6'h2A;
        endcase
    endfunction

    function automatic alsu_cmd_t mkCmd(logic [2:0] op, logic [2:0] a, logic [2:0] b,
                                        logic c, logic redA);
        alsu_cmd_t r;
        r          = '0;
        r.opcode   = op;
        r.A        = a;
        r.B        = b;
        r.cin      = c;
        r.red_op_A = redA;
        return r;
    endfunction

    // Stand-in ALSU: output reflects the pins two edges after they change.
    alsu_cmd_t  pinVec;
    logic [5:0] alsuS1, alsuS2;
    assign pinVec   = {opcode, A, B, cin, serial_in, red_op_A, red_op_B,
                       bypass_A, bypass_B, direction};
    assign alsu_out = alsuS2;
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            alsuS1 <= '0;
            alsuS2 <= '0;
        end else begin
            alsuS1 <= fakeAlsu(pinVec);
            alsuS2 <= alsuS1;
        end
    end

    // Reference model state: queued commands and results due at a given edge.
    typedef struct { alsu_cmd_t c; logic [3:0] tag; } entry_t;
    typedef struct { int due; logic [3:0] tag; logic inv; logic [5:0] out; } due_t;
    entry_t    fifoQ[$];
    due_t      dueQ[$];
    int        edgeNum  = 0;
    bit        readyEn  = 0;
    alsu_cmd_t expPins  = '0;
    bit        expValid = 0;
    logic [3:0] expTag  = '0;
    bit        expInv   = 0;
    logic [5:0] expOut  = '0;
    int        expErr   = 0;

    function automatic bit illegal(alsu_cmd_t c);
        return (c.opcode >= 3'd6) || ((c.red_op_A || c.red_op_B) && c.opcode > 3'd1);
    endfunction

    // Model step: each edge issues the oldest queued command unless held,
    // then takes the offered command if there was room before the edge.
    initial forever begin
        @(posedge clk or posedge reset);
        if (reset) begin
            fifoQ.delete();
            dueQ.delete();
            readyEn  = 0;
            expPins  = '0;
            expValid = 0;
            expErr   = 0;
        end else begin
            bit doIssue;
            bit doPush;
            edgeNum++;
            doIssue  = (fifoQ.size() > 0) && !hold;
            doPush   = cmd_valid && readyEn && (fifoQ.size() < DEPTH);
            expValid = 0;
            if (dueQ.size() > 0 && dueQ[0].due == edgeNum) begin
                due_t d;
                d        = dueQ.pop_front();
                expValid = 1;
                expTag   = d.tag;
                expInv   = d.inv;
                expOut   = d.out;
            end
            if (doIssue) begin
                entry_t e;
                e       = fifoQ.pop_front();
                expPins = e.c;
                dueQ.push_back('{edgeNum + LATENCY + 1, e.tag, illegal(e.c), fakeAlsu(e.c)});
                if (illegal(e.c) && expErr < 255) expErr++;
            end else begin
                expPins = '0;
            end
            if (doPush) fifoQ.push_back('{cmd, cmd_tag});
            readyEn = 1;
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Every-cycle comparison of the DUT against the model on the falling edge.
    initial forever begin
        @(negedge clk);
        checkOutput("cmd_ready", 32'(cmd_ready), 32'(readyEn && fifoQ.size() < DEPTH));
        checkOutput("pins", 32'(pinVec), 32'(expPins));
        checkOutput("res_valid", 32'(res_valid), 32'(expValid));
        checkOutput("err_cnt", 32'(err_cnt), 32'(expErr));
        if (expValid) begin
            checkOutput("res_tag", 32'(res_tag), 32'(expTag));
            checkOutput("res_invalid", 32'(res_invalid), 32'(expInv));
            checkOutput("res_out", 32'(res_out), 32'(expOut));
        end
    end

    task automatic applyStimulus(input logic v, input alsu_cmd_t c, input logic [3:0] t,
                                 input logic h);
        cmd_valid = v;
        cmd       = c;
        cmd_tag   = t;
        hold      = h;
        @(posedge clk);
        #1;
    endtask

    task automatic idleCycles(input int n, inout int nValid, inout int nInv);
        for (int i = 0; i < n; i++) begin
            applyStimulus(1'b0, '0, 4'd0, 1'b0);
            if (res_valid) nValid++;
            if (res_valid && res_invalid) nInv++;
        end
    endtask

    initial begin
        int nValid;
        int nInv;
        logic       seenValid [7];
        logic [3:0] seenTag [7];

        // Reset release
        repeat (3) @(posedge clk);
        #1;
        checkOutput("rst_ready", 32'(cmd_ready), 32'd0);
        checkOutput("rst_pins", 32'(pinVec), 32'd0);
        checkOutput("rst_res", 32'({res_valid, res_out, res_tag, res_invalid}), 32'd0);
        checkOutput("rst_err", 32'(err_cnt), 32'd0);
        reset = 1'b0;
        checkOutput("ready_low_after_release", 32'(cmd_ready), 32'd0);
        applyStimulus(1'b0, '0, 4'd0, 1'b0);
        checkOutput("ready_high_one_edge", 32'(cmd_ready), 32'd1);

        // Single ADD 3+2, tag 5
        applyStimulus(1'b1, mkCmd(3'd2, 3'd3, 3'd2, 1'b0, 1'b0), 4'd5, 1'b0);
        applyStimulus(1'b0, '0, 4'd0, 1'b0);
        checkOutput("add_pin_opcode", 32'(opcode), 32'd2);
        checkOutput("add_pin_AB", 32'({A, B}), 32'h1A);
        applyStimulus(1'b0, '0, 4'd0, 1'b0);
        applyStimulus(1'b0, '0, 4'd0, 1'b0);
        checkOutput("add_not_yet", 32'(res_valid), 32'd0);
        applyStimulus(1'b0, '0, 4'd0, 1'b0);
        checkOutput("add_res_valid", 32'(res_valid), 32'd1);
        checkOutput("add_res_out", 32'(res_out), 32'd5);
        checkOutput("add_res_tag", 32'(res_tag), 32'd5);
        checkOutput("add_res_invalid", 32'(res_invalid), 32'd0);
        applyStimulus(1'b0, '0, 4'd0, 1'b0);
        checkOutput("add_strobe_one_cycle", 32'(res_valid), 32'd0);

        // Hold while offering five commands into a four-entry FIFO
        for (int i = 0; i < 5; i++) begin
            checkOutput("hold_ready", 32'(cmd_ready), (i < 4) ? 32'd1 : 32'd0);
            applyStimulus(1'b1, mkCmd(3'(i), 3'(i + 1), 3'(i + 2), 1'b1, 1'b0), 4'(i), 1'b1);
        end
        for (int j = 0; j < 7; j++) begin
            applyStimulus(1'b0, '0, 4'd0, 1'b0);
            seenValid[j] = res_valid;
            seenTag[j]   = res_tag;
        end
        for (int j = 3; j < 7; j++) begin
            checkOutput("drain_valid", 32'(seenValid[j]), 32'd1);
            checkOutput("drain_tag", 32'(seenTag[j]), 32'(j - 3));
        end
        idleCycles(2, nValid, nInv);

        // Two invalid commands: illegal opcode, then reduction with ADD
        nValid = 0;
        nInv   = 0;
        applyStimulus(1'b1, mkCmd(3'd7, 3'd1, 3'd1, 1'b0, 1'b0), 4'd1, 1'b0);
        applyStimulus(1'b1, mkCmd(3'd2, 3'd1, 3'd1, 1'b0, 1'b1), 4'd2, 1'b0);
        idleCycles(6, nValid, nInv);
        checkOutput("inv_results", 32'(nValid), 32'd2);
        checkOutput("inv_flags", 32'(nInv), 32'd2);
        checkOutput("inv_err_cnt", 32'(err_cnt), 32'd2);

        // 300 more invalid commands saturate the counter
        for (int i = 0; i < 300; i++)
            applyStimulus(1'b1, mkCmd(3'd6, 3'(i), 3'(i >> 3), 1'b0, 1'b0), 4'(i), 1'b0);
        idleCycles(5, nValid, nInv);
        checkOutput("err_saturate", 32'(err_cnt), 32'd255);

        // Continuous stream: push and pop on the same edges
        nValid = 0;
        nInv   = 0;
        for (int i = 0; i < 10; i++) begin
            applyStimulus(1'b1, mkCmd(3'(i % 6), 3'(i), 3'(7 - i), 1'(i), 1'b0), 4'(i + 3), 1'b0);
            if (res_valid) nValid++;
        end
        idleCycles(6, nValid, nInv);
        checkOutput("stream_results", 32'(nValid), 32'd10);

        // Reset with two commands queued and two in flight
        for (int i = 0; i < 4; i++)
            applyStimulus(1'b1, mkCmd(3'd3, 3'(i + 2), 3'd3, 1'b0, 1'b0), 4'(i + 8), 1'b1);
        applyStimulus(1'b0, '0, 4'd0, 1'b0);
        applyStimulus(1'b0, '0, 4'd0, 1'b0);
        checkOutput("pre_reset_pins", 32'(opcode), 32'd3);
        reset = 1'b1;
        #1;
        checkOutput("reset_pins_nop", 32'(pinVec), 32'd0);
        checkOutput("reset_no_result", 32'(res_valid), 32'd0);
        checkOutput("reset_err_clear", 32'(err_cnt), 32'd0);
        @(posedge clk);
        @(posedge clk);
        #1;
        reset  = 1'b0;
        nValid = 0;
        idleCycles(8, nValid, nInv);
        checkOutput("post_reset_results", 32'(nValid), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
